// File: rtl/pc_stack_if.sv
// Request/status bundle between a sequencer and the pc_stack program-counter unit.
// The sequencer owns the master side; pc_stack owns the slave side.
interface pc_stack_if #(
   parameter int AW = 16,
   parameter int DW = 8
);
   logic          pcEn;
   logic          branch;
   logic          jump;
   logic          call;
   logic          ret;
   logic [DW-1:0] disp;
   logic [AW-1:0] dSrc;
   logic          clrErr;
   logic [AW-1:0] pc;
   logic [AW-1:0] pc1;
   logic [AW-1:0] raTop;
   logic          rasEmpty;
   logic          rasFull;
   logic          rasOvf;
   logic          rasUnf;

   modport master (
      output pcEn, branch, jump, call, ret, disp, dSrc, clrErr,
      input  pc, pc1, raTop, rasEmpty, rasFull, rasOvf, rasUnf
   );

   modport slave (
      input  pcEn, branch, jump, call, ret, disp, dSrc, clrErr,
      output pc, pc1, raTop, rasEmpty, rasFull, rasOvf, rasUnf
   );
endinterface

// File: rtl/pc_stack.sv
// Program counter with relative branch, absolute jump, and a circular return-address
// stack whose oldest entry is overwritten when a call arrives while it is full.
module pc_stack #(
   parameter int            AW        = 16,
   parameter int            DW        = 8,
   parameter int            DEPTH     = 4,
   parameter logic [AW-1:0] RESET_VEC = '0
) (
   input logic        clk,
   input logic        rst,
   pc_stack_if.slave  bus
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;

   logic [AW-1:0] pc_q, pc_d, pc1;
   logic [AW-1:0] ras_q [DEPTH];
   logic [PW-1:0] top_q, top_d, wr_idx;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          wr_en;
   logic [AW-1:0] ras_top;
   logic          empty, full;
   logic          ovf_q, unf_q, ovf_set, unf_set;

   assign pc1     = pc_q + AW'(1);
   assign empty   = (cnt_q == '0);
   assign full    = (cnt_q == CW'(DEPTH));
   assign ras_top = empty ? '0 : ras_q[top_q];

   // top_q indexes the newest entry; the slot after it is the oldest once full.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path infers a latch.
      pc_d    = pc_q;
      top_d   = top_q;
      cnt_d   = cnt_q;
      wr_en   = 1'b0;
      wr_idx  = top_q;
      ovf_set = 1'b0;
      unf_set = 1'b0;
      if (bus.pcEn) begin
         if (bus.ret) begin
            if (empty) begin
               pc_d    = pc1;
               unf_set = 1'b1;
            end else if (bus.call) begin
               pc_d  = ras_top;
               wr_en = 1'b1;
            end else begin
               pc_d  = ras_top;
               top_d = top_q - PW'(1);
               cnt_d = cnt_q - CW'(1);
            end
         end else if (bus.call) begin
            pc_d   = bus.dSrc;
            top_d  = top_q + PW'(1);
            wr_idx = top_q + PW'(1);
            wr_en  = 1'b1;
            if (full) ovf_set = 1'b1;
            else      cnt_d   = cnt_q + CW'(1);
         end else if (bus.jump) begin
            pc_d = bus.dSrc;
         end else if (bus.branch) begin
            pc_d = pc1 + AW'($signed(bus.disp));
         end else begin
            pc_d = pc1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q  <= RESET_VEC;
         top_q <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
         // NOTE: the stack storage is reset too, so raTop and stale slots are defined after reset.
         for (int i = 0; i < DEPTH; i++) ras_q[i] <= '0;
      end else begin
         pc_q  <= pc_d;
         top_q <= top_d;
         cnt_q <= cnt_d;
         if (wr_en) ras_q[wr_idx] <= pc1;
         ovf_q <= ovf_set | (ovf_q & ~bus.clrErr);
         unf_q <= unf_set | (unf_q & ~bus.clrErr);
      end
   end

   assign bus.pc       = pc_q;
   assign bus.pc1      = pc1;
   assign bus.raTop    = ras_top;
   assign bus.rasEmpty = empty;
   assign bus.rasFull  = full;
   assign bus.rasOvf   = ovf_q;
   assign bus.rasUnf   = unf_q;
endmodule

// File: tb/tb_pc_stack.sv
// Directed bench for pc_stack (AW=16, DW=8, DEPTH=4, RESET_VEC=0).
// Inputs change 1 time unit after each rising edge; outputs are checked there too.
module tb_pc_stack;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;

   pc_stack_if #(.AW(16), .DW(8)) bus ();

   pc_stack #(.AW(16), .DW(8), .DEPTH(4), .RESET_VEC(16'h0000)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.pcEn   = 1'b0;
      bus.branch = 1'b0;
      bus.jump   = 1'b0;
      bus.call   = 1'b0;
      bus.ret    = 1'b0;
      bus.disp   = '0;
      bus.dSrc   = '0;
      bus.clrErr = 1'b0;
   endtask

   task automatic do_jump(input logic [15:0] tgt);
      idle();
      bus.pcEn = 1'b1; bus.jump = 1'b1; bus.dSrc = tgt;
      tick();
      idle();
   endtask

   task automatic do_call(input logic [15:0] tgt);
      idle();
      bus.pcEn = 1'b1; bus.call = 1'b1; bus.dSrc = tgt;
      tick();
      idle();
   endtask

   task automatic do_ret();
      idle();
      bus.pcEn = 1'b1; bus.ret = 1'b1;
      tick();
      idle();
   endtask

   task automatic do_inc();
      idle();
      bus.pcEn = 1'b1;
      tick();
      idle();
   endtask

   task automatic pulse_reset();
      rst = 1'b0;
      #2;
      rst = 1'b1;
   endtask

   initial begin
      logic [15:0] exp_ret [4];
      exp_ret[0] = 16'h0051; exp_ret[1] = 16'h0041;
      exp_ret[2] = 16'h0031; exp_ret[3] = 16'h0021;
      idle();

      // Reset state
      #1;
      check("rst_pc",    bus.pc,       16'h0000);
      check("rst_pc1",   bus.pc1,      16'h0001);
      check("rst_ratop", bus.raTop,    16'h0000);
      check("rst_empty", bus.rasEmpty, 1'b1);
      check("rst_full",  bus.rasFull,  1'b0);
      check("rst_ovf",   bus.rasOvf,   1'b0);
      check("rst_unf",   bus.rasUnf,   1'b0);
      tick();
      rst = 1'b1;
      tick();
      check("hold_no_en", bus.pc, 16'h0000);

      // Plain increment
      for (int i = 1; i <= 3; i++) begin
         do_inc();
         check($sformatf("inc_pc%0d", i),  bus.pc,  16'(i));
         check($sformatf("inc_pc1%0d", i), bus.pc1, 16'(i + 1));
      end

      // Branches: +127 then -128
      pulse_reset();
      do_inc();
      check("br_start", bus.pc, 16'h0001);
      bus.pcEn = 1'b1; bus.branch = 1'b1; bus.disp = 8'h7F;
      tick();
      check("br_pos", bus.pc, 16'h0081);
      bus.disp = 8'h80;
      tick();
      idle();
      check("br_neg", bus.pc, 16'h0002);

      // Jump beats branch; wrap at 0xFFFF
      bus.pcEn = 1'b1; bus.jump = 1'b1; bus.branch = 1'b1; bus.disp = 8'h05; bus.dSrc = 16'hFFFF;
      tick();
      idle();
      check("jmp_pc",  bus.pc,  16'hFFFF);
      check("jmp_pc1", bus.pc1, 16'h0000);
      do_inc();
      check("wrap_pc", bus.pc, 16'h0000);

      // Five calls into a 4-deep stack
      do_jump(16'h0010);
      for (int i = 1; i <= 5; i++) begin
         do_call(16'(16 * i + 15));
         check($sformatf("call%0d_pc", i),    bus.pc,    16'(16 * i + 15));
         check($sformatf("call%0d_top", i),   bus.raTop, 16'(16 * i + 1));
         check($sformatf("call%0d_full", i),  bus.rasFull, (i >= 4) ? 1'b1 : 1'b0);
         check($sformatf("call%0d_ovf", i),   bus.rasOvf,  (i >= 5) ? 1'b1 : 1'b0);
         if (i < 5) do_inc();
      end
      for (int i = 0; i < 4; i++) begin
         do_ret();
         check($sformatf("ret%0d_pc", i), bus.pc, exp_ret[i]);
      end
      check("ret_empty", bus.rasEmpty, 1'b1);
      check("ret_ratop", bus.raTop,    16'h0000);
      check("pre_unf",   bus.rasUnf,   1'b0);
      do_ret();
      check("unf_pc",   bus.pc,     16'h0022);
      check("unf_flag", bus.rasUnf, 1'b1);
      check("ovf_keep", bus.rasOvf, 1'b1);
      bus.clrErr = 1'b1;
      tick();
      idle();
      check("clr_ovf", bus.rasOvf, 1'b0);
      check("clr_unf", bus.rasUnf, 1'b0);
      check("clr_pc",  bus.pc,     16'h0022);

      // Set event wins over a simultaneous clear
      bus.pcEn = 1'b1; bus.ret = 1'b1; bus.clrErr = 1'b1;
      tick();
      idle();
      check("setwins_unf", bus.rasUnf, 1'b1);
      check("setwins_pc",  bus.pc,     16'h0023);
      bus.clrErr = 1'b1;
      tick();
      idle();

      // Disabled call is ignored
      do_jump(16'h01FF);
      do_call(16'h0100);
      check("sw_pre_top", bus.raTop, 16'h0200);
      bus.pcEn = 1'b0; bus.call = 1'b1; bus.dSrc = 16'h1234;
      tick();
      idle();
      check("dis_pc",    bus.pc,       16'h0100);
      check("dis_top",   bus.raTop,    16'h0200);
      check("dis_empty", bus.rasEmpty, 1'b0);

      // ret+call swaps top
      bus.pcEn = 1'b1; bus.ret = 1'b1; bus.call = 1'b1; bus.dSrc = 16'h7777;
      tick();
      idle();
      check("swap_pc",  bus.pc,    16'h0200);
      check("swap_top", bus.raTop, 16'h0101);
      do_ret();
      check("swap_pop_pc",    bus.pc,       16'h0101);
      check("swap_pop_empty", bus.rasEmpty, 1'b1);

      // ret+call on empty stack behaves as underflow
      bus.pcEn = 1'b1; bus.ret = 1'b1; bus.call = 1'b1; bus.dSrc = 16'h5555;
      tick();
      idle();
      check("swe_pc",    bus.pc,       16'h0102);
      check("swe_empty", bus.rasEmpty, 1'b1);
      check("swe_unf",   bus.rasUnf,   1'b1);

      // Async reset between edges during a call sequence
      do_call(16'h0300);
      bus.pcEn = 1'b1; bus.call = 1'b1; bus.dSrc = 16'h0400;
      #2;
      rst = 1'b0;
      #1;
      check("arst_pc",    bus.pc,       16'h0000);
      check("arst_empty", bus.rasEmpty, 1'b1);
      check("arst_unf",   bus.rasUnf,   1'b0);
      check("arst_ovf",   bus.rasOvf,   1'b0);
      tick();
      check("arst_hold", bus.pc, 16'h0000);
      idle();
      rst = 1'b1;
      tick();
      check("arst_after_pc",    bus.pc,       16'h0000);
      check("arst_after_empty", bus.rasEmpty, 1'b1);
      do_inc();
      check("arst_first_inc", bus.pc, 16'h0001);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/pc_stack.md
PC_STACK -- requirements
Module: pc_stack

Interface
REQ-001 Parameter AW, default 16, program-counter and address width in bits.
REQ-002 Parameter DW, default 8, branch displacement width in bits (two's complement).
REQ-003 Parameter DEPTH, default 4, return-address-stack (RAS) entry count, power of two, >=2.
REQ-004 Parameter RESET_VEC, default 0, value loaded into pc on reset.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 pcEn  input  1  advance enable; when 0, no state changes.
REQ-008 branch  input  1  PC-relative branch request.
REQ-009 jump  input  1  absolute jump request.
REQ-010 call  input  1  jump to dSrc and push return address.
REQ-011 ret  input  1  pop return address into pc.
REQ-012 disp  input  DW  signed branch displacement.
REQ-013 dSrc  input  AW  absolute jump/call target.
REQ-014 clrErr  input  1  clears sticky error flags.
REQ-015 pc  output  AW  current program counter, registered.
REQ-016 pc1  output  AW  pc+1 mod 2^AW, combinational from pc.
REQ-017 raTop  output  AW  top RAS entry; 0 when empty.
REQ-018 rasEmpty / rasFull  output  1 each  RAS occupancy == 0 / == DEPTH.
REQ-019 rasOvf / rasUnf  output  1 each  sticky overflow / underflow flags.

Function
REQ-020 pcEn=1 SHALL select one action by priority ret > call > jump > branch > increment.
REQ-021 Increment: pc <= pc1.
REQ-022 Branch: pc <= pc1 + sign-extend(disp), result truncated to AW bits.
REQ-023 Jump: pc <= dSrc.
REQ-024 Call: pc <= dSrc; push pc1; occupancy +1.
REQ-025 Call when rasFull SHALL overwrite the oldest entry (circular), keep occupancy DEPTH, set rasOvf.
REQ-026 Ret when not empty: pc <= raTop; pop; occupancy -1.
REQ-027 Ret when rasEmpty SHALL set pc <= pc1, leave RAS unchanged, set rasUnf.
REQ-028 ret and call together SHALL swap: pc <= raTop, top entry <= pc1, occupancy unchanged; if empty, treated as REQ-027 with call ignored.
REQ-029 pcEn=0 SHALL hold pc, RAS contents, occupancy; all requests ignored.
REQ-030 All address arithmetic wraps mod 2^AW; no carry-out reported.
REQ-031 rasOvf/rasUnf SHALL stay set until clrErr=1 at a rising edge; a same-cycle set event wins over clrErr.
REQ-032 clrErr SHALL act regardless of pcEn.
REQ-033 Action takes effect one cycle after request edge; pc1, raTop, rasEmpty, rasFull follow register state combinationally.

Reset
REQ-034 rst=0 SHALL immediately, independent of clk, force pc=RESET_VEC, occupancy 0, all RAS entries 0, rasOvf=rasUnf=0.
REQ-035 Reset mid-operation SHALL discard any in-flight request; first action uses edges after rst returns high.
REQ-036 After reset: pc1=RESET_VEC+1, raTop=0, rasEmpty=1, rasFull=0.

Verification (AW=16, DW=8, DEPTH=4, RESET_VEC=0)
REQ-037 Reset, pcEn=1 for 3 cycles -> pc 0x0001, 0x0002, 0x0003; pc1 always pc+1.
REQ-038 pc=0x0001, branch disp=0x7F -> pc=0x0081; then branch disp=0x80 -> pc=0x0002.
REQ-039 Jump dSrc=0xFFFF, then increment -> pc=0x0000; pc1 at 0xFFFF reads 0x0000.
REQ-040 Calls from pc 0x0010,0x0020,0x0030,0x0040,0x0050 (dSrc=pc+0x0F) -> rasFull after 4th, rasOvf after 5th; 4 rets yield 0x0051,0x0041,0x0031,0x0021; 5th ret -> rasUnf=1, pc=pc+1; clrErr clears both flags.
REQ-041 pcEn=0 with call=1, dSrc=0x1234 -> pc, raTop, occupancy unchanged; ret+call at pc=0x0100, raTop=0x0200 -> pc=0x0200, raTop=0x0101.
REQ-042 Assert rst low between edges during a call sequence -> pc=0x0000, rasEmpty=1, flags 0 before next edge.
